// File: rtl/load_store_unit_pkg.sv
// Shared LSU definitions: funct3 codes, FSM states, fault causes.
// Also holds the legality and alignment helpers used at accept.
package load_store_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RESP,
        DONE,
        FAULT
    } lsu_state_e;

    typedef enum logic [1:0] {
        FaultNone     = 2'b00,
        FaultMisalign = 2'b01,
        FaultBus      = 2'b10,
        FaultIllegal  = 2'b11
    } lsu_fault_e;

    // Stores only have SB/SH/SW; loads reject 011 and 11x.
    function automatic logic f3_illegal(
        input logic       we,
        input logic [2:0] f3
    );
        if (we) begin
            return f3 > F3_LW;
        end
        return (f3 == 3'b011) || (f3[2:1] == 2'b11);
    endfunction

    // Access size lives in funct3[1:0]: 00 byte, 01 half, 10 word.
    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] off
    );
        unique case (size)
            2'b01:   return off[0];
            2'b10:   return |off;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational lane logic: store strobes/data replication and
// load byte/halfword extraction with sign or zero extension.
// Ports:
//   st_funct3, st_off, st_data -> wstrb, wdata  (store side)
//   ld_funct3, ld_off, rdata   -> load_data     (load side)
module lsu_data_align
    import load_store_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]        st_funct3,
    input  logic [1:0]        st_off,
    input  logic [XLEN-1:0]   st_data,
    input  logic [2:0]        ld_funct3,
    input  logic [1:0]        ld_off,
    input  logic [XLEN-1:0]   rdata,
    output logic [XLEN/8-1:0] wstrb,
    output logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   load_data
);

    localparam int NB = XLEN / 8;

    logic [XLEN-1:0] shifted;

    assign shifted = rdata >> {ld_off, 3'b000};

    always_comb begin
        wstrb = '0;
        wdata = st_data;
        case (st_funct3)
            F3_LB: begin
                wstrb = NB'(1) << st_off;
                wdata = {NB{st_data[7:0]}};
            end
            F3_LH: begin
                wstrb = NB'(3) << st_off;
                wdata = {(XLEN/16){st_data[15:0]}};
            end
            default: begin
                wstrb = '1;
                wdata = st_data;
            end
        endcase
    end

    always_comb begin
        load_data = rdata;
        case (ld_funct3)
            F3_LB:  load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_LH:  load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_LBU: load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_LHU: load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts one op from the control unit, runs a
// valid/ready request plus response on the data bus, reports done/fault.
// Ports:
//   i_clk, i_rst                         clock, sync active-high reset
//   i_cu_lsu_* / o_cu_lsu_ready          op handshake from control unit
//   i_alu_addr, i_rf_rs2_data            address and store source
//   o_lsu_load_data/done/fault/cause     results and status pulses
//   o_dmem_* / i_dmem_*                  data memory request/response
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cu_lsu_valid,
    output logic              o_cu_lsu_ready,
    input  logic              i_cu_lsu_we,
    input  logic [2:0]        i_cu_lsu_funct3,
    input  logic [XLEN-1:0]   i_alu_addr,
    input  logic [XLEN-1:0]   i_rf_rs2_data,
    output logic [XLEN-1:0]   o_lsu_load_data,
    output logic              o_lsu_done,
    output logic              o_lsu_fault,
    output logic [1:0]        o_lsu_fault_cause,
    output logic              o_dmem_req_valid,
    input  logic              i_dmem_req_ready,
    output logic [XLEN-1:0]   o_dmem_addr,
    output logic              o_dmem_we,
    output logic [XLEN/8-1:0] o_dmem_wstrb,
    output logic [XLEN-1:0]   o_dmem_wdata,
    input  logic              i_dmem_rsp_valid,
    input  logic [XLEN-1:0]   i_dmem_rdata,
    input  logic              i_dmem_rsp_err
);

    lsu_state_e        state;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic [XLEN/8-1:0] st_strb;
    logic [XLEN-1:0]   st_data;
    logic [XLEN-1:0]   ld_data;
    logic              bad_f3;
    logic              bad_align;

    // Store lanes come from the live request so they can be registered
    // at accept; load extraction uses the captured op.
    lsu_data_align #(
        .XLEN (XLEN)
    ) u_align (
        .st_funct3 (i_cu_lsu_funct3),
        .st_off    (i_alu_addr[1:0]),
        .st_data   (i_rf_rs2_data),
        .ld_funct3 (f3_q),
        .ld_off    (off_q),
        .rdata     (i_dmem_rdata),
        .wstrb     (st_strb),
        .wdata     (st_data),
        .load_data (ld_data)
    );

    assign bad_f3    = f3_illegal(i_cu_lsu_we, i_cu_lsu_funct3);
    assign bad_align = misaligned(i_cu_lsu_funct3[1:0], i_alu_addr[1:0]);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state             <= IDLE;
            we_q              <= 1'b0;
            f3_q              <= 3'b000;
            off_q             <= 2'b00;
            o_cu_lsu_ready    <= 1'b1;
            o_lsu_load_data   <= '0;
            o_lsu_done        <= 1'b0;
            o_lsu_fault       <= 1'b0;
            o_lsu_fault_cause <= FaultNone;
            o_dmem_req_valid  <= 1'b0;
            o_dmem_addr       <= '0;
            o_dmem_we         <= 1'b0;
            o_dmem_wstrb      <= '0;
            o_dmem_wdata      <= '0;
        end else begin
            o_lsu_done        <= 1'b0;
            o_lsu_fault       <= 1'b0;
            o_lsu_fault_cause <= FaultNone;
            unique case (state)
                IDLE: begin
                    if (i_cu_lsu_valid) begin
                        o_cu_lsu_ready <= 1'b0;
                        we_q           <= i_cu_lsu_we;
                        f3_q           <= i_cu_lsu_funct3;
                        off_q          <= i_alu_addr[1:0];
                        if (bad_f3) begin
                            state             <= FAULT;
                            o_lsu_fault       <= 1'b1;
                            o_lsu_fault_cause <= FaultIllegal;
                        end else if (bad_align) begin
                            state             <= FAULT;
                            o_lsu_fault       <= 1'b1;
                            o_lsu_fault_cause <= FaultMisalign;
                        end else begin
                            state            <= REQ;
                            o_dmem_req_valid <= 1'b1;
                            o_dmem_addr      <= {i_alu_addr[XLEN-1:2], 2'b00};
                            o_dmem_we        <= i_cu_lsu_we;
                            o_dmem_wstrb     <= i_cu_lsu_we ? st_strb : '0;
                            o_dmem_wdata     <= i_cu_lsu_we ? st_data : '0;
                        end
                    end
                end
                REQ: begin
                    if (i_dmem_req_ready) begin
                        state            <= RESP;
                        o_dmem_req_valid <= 1'b0;
                    end
                end
                RESP: begin
                    if (i_dmem_rsp_valid) begin
                        if (i_dmem_rsp_err) begin
                            state             <= FAULT;
                            o_lsu_fault       <= 1'b1;
                            o_lsu_fault_cause <= FaultBus;
                        end else begin
                            state      <= DONE;
                            o_lsu_done <= 1'b1;
                            if (!we_q) begin
                                o_lsu_load_data <= ld_data;
                            end
                        end
                    end
                end
                DONE, FAULT: begin
                    state          <= IDLE;
                    o_cu_lsu_ready <= 1'b1;
                end
                default: begin
                    state          <= IDLE;
                    o_cu_lsu_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed ops push expected
// completions; a negedge monitor pops and compares on done/fault.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        cu_valid;
    logic        cu_ready;
    logic        cu_we;
    logic [2:0]  cu_f3;
    logic [31:0] alu_addr;
    logic [31:0] rs2;
    logic [31:0] load_data;
    logic        done;
    logic        fault;
    logic [1:0]  cause;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] dmem_addr;
    logic        dmem_we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic [31:0] rdata;
    logic        rsp_err;

    always #5 clk = ~clk;

    load_store_unit #(.XLEN(32)) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_cu_lsu_valid    (cu_valid),
        .o_cu_lsu_ready    (cu_ready),
        .i_cu_lsu_we       (cu_we),
        .i_cu_lsu_funct3   (cu_f3),
        .i_alu_addr        (alu_addr),
        .i_rf_rs2_data     (rs2),
        .o_lsu_load_data   (load_data),
        .o_lsu_done        (done),
        .o_lsu_fault       (fault),
        .o_lsu_fault_cause (cause),
        .o_dmem_req_valid  (req_valid),
        .i_dmem_req_ready  (req_ready),
        .o_dmem_addr       (dmem_addr),
        .o_dmem_we         (dmem_we),
        .o_dmem_wstrb      (wstrb),
        .o_dmem_wdata      (wdata),
        .i_dmem_rsp_valid  (rsp_valid),
        .i_dmem_rdata      (rdata),
        .i_dmem_rsp_err    (rsp_err)
    );

    typedef struct packed {
        logic        is_fault;
        logic [1:0]  cause;
        logic [31:0] data;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_ld = 32'h0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && (done || fault)) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_completion done=%0b fault=%0b",
                         done, fault);
            end else begin
                e = sbq.pop_front();
                chk("mon_fault", {31'b0, fault}, {31'b0, e.is_fault});
                chk("mon_done", {31'b0, done}, {31'b0, !e.is_fault});
                if (e.is_fault)
                    chk("mon_cause", {30'b0, cause}, {30'b0, e.cause});
                chk("mon_load_data", load_data, e.data);
            end
        end
    end

    task automatic run_op(
        input logic        we,
        input logic [2:0]  f3,
        input logic [31:0] addr,
        input logic [31:0] sdata,
        input logic [31:0] rword,
        input logic        err,
        input int          stall,
        input logic        acc_fault,
        input logic [1:0]  acc_cause,
        input logic [3:0]  exp_strb,
        input logic [31:0] exp_wdata,
        input logic [31:0] exp_ld
    );
        exp_t        e;
        logic [31:0] waddr;
        waddr = {addr[31:2], 2'b00};
        if (!we && !acc_fault && !err)
            model_ld = exp_ld;
        e.is_fault = acc_fault || err;
        e.cause    = acc_fault ? acc_cause : (err ? 2'b10 : 2'b00);
        e.data     = model_ld;
        sbq.push_back(e);

        @(negedge clk);
        chk("ready_before_op", {31'b0, cu_ready}, 32'd1);
        cu_valid = 1'b1;
        cu_we    = we;
        cu_f3    = f3;
        alu_addr = addr;
        rs2      = sdata;
        @(negedge clk);
        cu_valid = 1'b0;
        if (acc_fault) begin
            chk("accept_fault_pulse", {31'b0, fault}, 32'd1);
            chk("accept_fault_no_req", {31'b0, req_valid}, 32'd0);
            @(negedge clk);
            chk("fault_no_req_c2", {31'b0, req_valid}, 32'd0);
            chk("fault_ready_c2", {31'b0, cu_ready}, 32'd1);
            return;
        end
        chk("req_valid_c1", {31'b0, req_valid}, 32'd1);
        chk("dmem_addr", dmem_addr, waddr);
        chk("dmem_we", {31'b0, dmem_we}, {31'b0, we});
        chk("dmem_wstrb", {28'b0, wstrb}, {28'b0, exp_strb});
        if (we)
            chk("dmem_wdata", wdata, exp_wdata);
        req_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            rsp_valid = 1'b1;
            rsp_err   = 1'b0;
            rdata     = 32'h5555AAAA;
            @(negedge clk);
            chk("stall_req_valid", {31'b0, req_valid}, 32'd1);
            chk("stall_addr", dmem_addr, waddr);
            chk("stall_wstrb", {28'b0, wstrb}, {28'b0, exp_strb});
            chk("stall_no_done", {31'b0, done | fault}, 32'd0);
        end
        rsp_valid = 1'b0;
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        chk("req_valid_drop", {31'b0, req_valid}, 32'd0);
        rsp_valid = 1'b1;
        rdata     = rword;
        rsp_err   = err;
        @(negedge clk);
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        chk("completion_c3", {31'b0, done | fault}, 32'd1);
        @(negedge clk);
        chk("ready_after", {31'b0, cu_ready}, 32'd1);
        chk("pulse_one_cycle", {31'b0, done | fault}, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        cu_valid  = 1'b0;
        cu_we     = 1'b0;
        cu_f3     = 3'b000;
        alu_addr  = 32'h0;
        rs2       = 32'h0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rdata     = 32'h0;
        rsp_err   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, cu_ready}, 32'd1);
        chk("rst_req_valid", {31'b0, req_valid}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_fault", {31'b0, fault}, 32'd0);
        chk("rst_cause", {30'b0, cause}, 32'd0);
        chk("rst_load_data", load_data, 32'h0);
        chk("rst_wstrb", {28'b0, wstrb}, 32'd0);
        chk("rst_addr", dmem_addr, 32'h0);
        rst = 1'b0;

        // we f3 addr rs2 rdata err stall accf cause strb wdata ld
        run_op(0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 0,
               0, 2'b00, 4'h0, 0, 32'hDEADBEEF);
        run_op(0, 3'b000, 32'h103, 0, 32'h80FF0011, 0, 0,
               0, 2'b00, 4'h0, 0, 32'hFFFFFF80);
        run_op(0, 3'b100, 32'h103, 0, 32'h80FF0011, 0, 0,
               0, 2'b00, 4'h0, 0, 32'h00000080);
        run_op(0, 3'b001, 32'h102, 0, 32'h80FF0011, 0, 0,
               0, 2'b00, 4'h0, 0, 32'hFFFF80FF);
        run_op(0, 3'b101, 32'h102, 0, 32'h80FF0011, 0, 0,
               0, 2'b00, 4'h0, 0, 32'h000080FF);
        run_op(1, 3'b001, 32'h202, 32'h1234ABCD, 32'hFFFFFFFF, 0, 0,
               0, 2'b00, 4'hC, 32'hABCDABCD, 0);
        run_op(1, 3'b000, 32'h201, 32'h0000005A, 32'h0, 0, 0,
               0, 2'b00, 4'h2, 32'h5A5A5A5A, 0);
        run_op(1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h0, 0, 0,
               0, 2'b00, 4'hF, 32'hCAFEF00D, 0);
        run_op(0, 3'b010, 32'h101, 0, 0, 0, 0,
               1, 2'b01, 4'h0, 0, 0);
        run_op(1, 3'b001, 32'h203, 32'h1111, 0, 0, 0,
               1, 2'b01, 4'h0, 0, 0);
        run_op(0, 3'b011, 32'h100, 0, 0, 0, 0,
               1, 2'b11, 4'h0, 0, 0);
        run_op(0, 3'b110, 32'h100, 0, 0, 0, 0,
               1, 2'b11, 4'h0, 0, 0);
        run_op(1, 3'b100, 32'h100, 32'h77, 0, 0, 0,
               1, 2'b11, 4'h0, 0, 0);
        run_op(0, 3'b010, 32'h104, 0, 32'h12345678, 1, 4,
               0, 2'b00, 4'h0, 0, 0);

        // Reset while waiting for a response, then a late response.
        @(negedge clk);
        cu_valid = 1'b1;
        cu_we    = 1'b0;
        cu_f3    = 3'b010;
        alu_addr = 32'h108;
        @(negedge clk);
        cu_valid  = 1'b0;
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        model_ld = 32'h0;
        chk("rst_mid_ready", {31'b0, cu_ready}, 32'd1);
        chk("rst_mid_req_valid", {31'b0, req_valid}, 32'd0);
        rsp_valid = 1'b1;
        rdata     = 32'h11223344;
        @(negedge clk);
        rsp_valid = 1'b0;
        chk("late_rsp_no_done", {31'b0, done}, 32'd0);
        chk("late_rsp_load_data", load_data, 32'h0);
        @(negedge clk);
        chk("late_rsp_ready", {31'b0, cu_ready}, 32'd1);

        run_op(0, 3'b010, 32'h10C, 0, 32'h0BADF00D, 0, 0,
               0, 2'b00, 4'h0, 0, 32'h0BADF00D);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", sbq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
